dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the byte-addressable data memory.
- Uses the same 3-bit WE access encoding on both sides.
- Load hits return data combinationally in the request cycle.
- Load misses stall the CPU while a multi-cycle FSM refills the whole line from backing memory.
- Stores pass straight through to backing memory in one cycle.

---
 rtl/dcache_direct.sv | 137 +++++++++++++
 tb/tb_dcache_direct.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through no-write-allocate data cache
module dcache_direct #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReq,
  input  logic [2:0]  WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Stall,
  output logic [2:0]  mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam int OFF_BITS  = $clog2(LINE_WORDS);
  localparam int LINE_BITS = 30 - OFF_BITS;
  localparam int TAG_BITS  = LINE_BITS - INDEX_BITS;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                state, next_state;
  logic [OFF_BITS-1:0]   cnt;
  logic [LINE_BITS-1:0]  base_line;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES][LINE_WORDS];

  logic [OFF_BITS-1:0]   req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] ref_idx;
  logic [TAG_BITS-1:0]   ref_tag;
  logic                  is_load, is_store, hit;
  logic [31:0]           hit_word, hit_shift;
  logic [7:0]            hit_byte;

  logic [31:0]           rd_c, mem_a_c, mem_wd_c;
  logic [2:0]            mem_we_c;
  logic                  stall_c;

  assign req_off   = A[OFF_BITS+1:2];
  assign req_idx   = A[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
  assign req_tag   = A[31:OFF_BITS+INDEX_BITS+2];
  assign ref_idx   = base_line[INDEX_BITS-1:0];
  assign ref_tag   = base_line[LINE_BITS-1:INDEX_BITS];

  assign is_load   = MemReq && (WE == 3'b000 || WE == 3'b010 || WE == 3'b110);
  assign is_store  = MemReq && (WE == 3'b001 || WE == 3'b011);
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word  = data_mem[req_idx][req_off];
  assign hit_shift = hit_word >> {A[1:0], 3'b000};
  assign hit_byte  = hit_shift[7:0];

  // next-state and unmasked outputs: hits answer now, misses stall, stores pass through
  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    rd_c       = 32'd0;
    mem_we_c   = 3'b000;
    mem_a_c    = 32'd0;
    mem_wd_c   = 32'd0;
    case (state)
      IDLE: begin
        if (is_load) begin
          if (hit) begin
            case (WE)
              3'b000:  rd_c = hit_word;
              3'b010:  rd_c = {{24{hit_byte[7]}}, hit_byte};
              default: rd_c = {24'd0, hit_byte};
            endcase
          end else begin
            stall_c    = 1'b1;
            next_state = REFILL;
          end
        end else if (is_store) begin
          mem_we_c = WE;
          mem_a_c  = A;
          mem_wd_c = WD;
        end
      end
      REFILL: begin
        stall_c = 1'b1;
        mem_a_c = {base_line, cnt, 2'b00};
        if (cnt == LAST_WORD) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // reset forces every CPU- and memory-facing output quiet, even mid-refill
  always_comb begin
    Stall  = stall_c  & ~rst;
    RD     = rst ? 32'd0  : rd_c;
    mem_WE = rst ? 3'b000 : mem_we_c;
    mem_A  = rst ? 32'd0  : mem_a_c;
    mem_WD = rst ? 32'd0  : mem_wd_c;
  end

  // control state: FSM, refill counter, latched line address, valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base_line <= '0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && is_load && !hit) begin
        base_line <= A[31:OFF_BITS+2];
        cnt       <= '0;
      end
      if (state == REFILL) begin
        cnt <= cnt + OFF_BITS'(1);
        if (cnt == LAST_WORD) valid[ref_idx] <= 1'b1;
      end
    end
  end

  // line storage: refill words arrive one per cycle; store hits keep the copy coherent
  always_ff @(posedge clk) begin
    if (state == REFILL) begin
      data_mem[ref_idx][cnt] <= mem_RD;
      if (cnt == LAST_WORD) tag_mem[ref_idx] <= ref_tag;
    end else if (is_store && hit) begin
      if (WE == 3'b001) data_mem[req_idx][req_off] <= WD;
      else              data_mem[req_idx][req_off][{A[1:0], 3'b000} +: 8] <= WD[7:0];
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - randomized self-checking bench for dcache_direct
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReq = 1'b0;
  logic [2:0]  WE = 3'b000;
  logic [31:0] A = 32'd0;
  logic [31:0] WD = 32'd0;
  logic [31:0] RD, mem_A, mem_WD, mem_RD;
  logic [2:0]  mem_WE;
  logic        Stall;

  dcache_direct #(.INDEX_BITS(4), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .MemReq(MemReq), .WE(WE), .A(A), .WD(WD),
    .RD(RD), .Stall(Stall), .mem_WE(mem_WE), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // backing memory (16 KB) driven by the DUT, and the bench's golden copy
  logic [31:0] bmem [0:4095];
  logic [31:0] gold [0:4095];
  logic        mem_ready = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h40: return 32'h11111111;
      'h41: return 32'h22222222;
      'h42: return 32'h33333333;
      'h43: return 32'hDEADBEEF;
      default: return 32'(i) * 32'h9E3779B1 ^ 32'h5A5AC3C3;
    endcase
  endfunction

  assign mem_RD = bmem[mem_A[13:2]];

  // backing memory: combinational read, writes on the clock edge
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) bmem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_WE == 3'b001) begin
      bmem[mem_A[13:2]] <= mem_WD;
    end else if (mem_WE == 3'b011) begin
      bmem[mem_A[13:2]][{mem_A[1:0], 3'b000} +: 8] <= mem_WD[7:0];
    end
  end

  // reference model: which memory line each cache slot holds (tag = A[31:8], index = A[7:4])
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // one CPU access: present it, follow any stall, check the response, update the model
  task automatic access(input bit mreq, input logic [2:0] we, input logic [31:0] a,
                        input logic [31:0] wd);
    bit          ld, st, hit;
    int          idx, n;
    logic [31:0] w, exp_rd, line;
    logic [7:0]  b;
    ld   = mreq && (we == 3'b000 || we == 3'b010 || we == 3'b110);
    st   = mreq && (we == 3'b001 || we == 3'b011);
    idx  = int'(a[7:4]);
    hit  = m_valid[idx] && (m_tag[idx] == a[31:8]);
    w    = gold[a[13:2]];
    b    = 8'(w >> (8 * a[1:0]));
    line = {a[31:4], 4'h0};
    if (!ld)               exp_rd = 32'd0;
    else if (we == 3'b000) exp_rd = w;
    else if (we == 3'b010) exp_rd = {{24{b[7]}}, b};
    else                   exp_rd = {24'd0, b};

    @(negedge clk);
    MemReq = mreq; WE = we; A = a; WD = wd;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 20) begin
      n++;
      if (n >= 2) check("refill_mem_A", mem_A, line + 32'((n - 2) * 4));
      @(posedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), (ld && !hit) ? 32'd5 : 32'd0);
    check("RD", RD, exp_rd);
    check("mem_WE", {29'd0, mem_WE}, st ? {29'd0, we} : 32'd0);
    check("mem_A", mem_A, st ? a : 32'd0);
    check("mem_WD", mem_WD, st ? wd : 32'd0);
    last_rd = RD;
    @(posedge clk);
    #1;
    MemReq = 1'b0;

    if (ld && !hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:8];
    end
    if (st) begin
      if (we == 3'b001) gold[a[13:2]] = wd;
      else              gold[a[13:2]][8 * a[1:0] +: 8] = wd[7:0];
      check("backing_mem", bmem[a[13:2]], gold[a[13:2]]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mism;
    logic [2:0]  we;
    logic [31:0] a;
    logic [2:0]  bad_we [3];
    bad_we = '{3'b100, 3'b101, 3'b111};
    for (int i = 0; i < 4096; i++) gold[i] = init_word(i);
    clear_model();

    // outputs held quiet under reset even with a request presented
    rst = 1'b1; MemReq = 1'b1; WE = 3'b000; A = 32'h100;
    #1;
    check("rst_Stall", {31'd0, Stall}, 32'd0);
    check("rst_RD", RD, 32'd0);
    check("rst_mem_WE", {29'd0, mem_WE}, 32'd0);
    check("rst_mem_A", mem_A, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; MemReq = 1'b0;

    // directed walk-through
    access(1, 3'b000, 32'h100, 0); check("tp_lw_100", last_rd, 32'h11111111);
    access(1, 3'b000, 32'h10C, 0); check("tp_lw_10C", last_rd, 32'hDEADBEEF);
    access(1, 3'b010, 32'h10F, 0); check("tp_lb_10F", last_rd, 32'hFFFFFFDE);
    access(1, 3'b110, 32'h10F, 0); check("tp_lbu_10F", last_rd, 32'h000000DE);
    access(1, 3'b011, 32'h10D, 32'h000000AA);
    access(1, 3'b000, 32'h10C, 0); check("tp_sb_hit", last_rd, 32'hDEADAAEF);
    check("tp_sb_bmem", bmem[12'h043], 32'hDEADAAEF);
    access(1, 3'b001, 32'h200, 32'hCAFEF00D);
    access(1, 3'b000, 32'h200, 0); check("tp_sw_miss", last_rd, 32'hCAFEF00D);
    access(1, 3'b000, 32'h100, 0);
    access(1, 3'b000, 32'h100, 0);
    access(1, 3'b000, 32'h1100, 0);
    access(1, 3'b000, 32'h100, 0); check("tp_conflict", last_rd, 32'h11111111);
    access(1, 3'b000, 32'h0F2, 0);

    // reset pulsed in the second refill cycle of a miss on the last line
    @(negedge clk);
    MemReq = 1'b1; WE = 3'b000; A = 32'h3F0;
    #1;
    check("abort_miss_stall", {31'd0, Stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_Stall", {31'd0, Stall}, 32'd0);
    check("abort_RD", RD, 32'd0);
    check("abort_mem_WE", {29'd0, mem_WE}, 32'd0);
    check("abort_mem_A", mem_A, 32'd0);
    check("abort_mem_WD", mem_WD, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; MemReq = 1'b0;
    clear_model();
    access(1, 3'b000, 32'h3F0, 0);

    // randomized traffic over four tags so hits, conflicts and byte lanes all occur
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0:       we = bad_we[$urandom_range(0, 2)];
        1, 2:    we = 3'b001;
        3, 4:    we = 3'b011;
        5:       we = 3'b010;
        6:       we = 3'b110;
        default: we = 3'b000;
      endcase
      a = 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 255));
      access($urandom_range(0, 9) != 0, we, a, $urandom);
    end

    mism = 0;
    for (int i = 0; i < 4096; i++) if (bmem[i] !== gold[i]) mism++;
    check("bmem_sweep", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
